// File: rtl/hex_marquee_ctrl.sv
// Scrolling-message sequencer for the six-digit HEX bank.
// Slides a stored symbol string right-to-left, pausing with blink at the end.
module hex_marquee_ctrl #(
   parameter int         MAX_LEN    = 16,
   parameter int         TICK_DIV   = 25000000,
   parameter int         HOLD_TICKS = 4,
   parameter logic [4:0] BLANK_CODE = 5'd31
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        wr_valid,
   input  logic [4:0]  wr_code,
   output logic        wr_ready,
   input  logic        start,
   input  logic        loop,
   input  logic        stop,
   output logic [29:0] digit_codes,
   output logic [5:0]  blink_mask,
   output logic        busy,
   output logic        pass_done
);

   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int PW = $clog2(MAX_LEN + 6);
   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
   localparam int HL = (HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SCROLL,
      HOLD
   } state_t;

   state_t        state;
   logic [LW-1:0] len;
   logic [PW-1:0] p;
   logic [TW-1:0] tcnt;
   logic [HW-1:0] hcnt;
   logic          held;
   logic [4:0]    sym_buf [MAX_LEN];

   logic tick;
   logic wr_accept;
   logic run;
   logic last_sym;
   logic end_pass;
   logic hold_last;

   assign run       = (state == SCROLL) || (state == HOLD);
   assign tick      = (tcnt == TW'(TICK_DIV - 1));
   assign wr_ready  = (state == LOAD) && (len < LW'(MAX_LEN));
   assign wr_accept = wr_valid && wr_ready && !stop && !load;
   assign last_sym  = (p == PW'(len) - PW'(1));
   assign end_pass  = (p == PW'(len) + PW'(5));
   assign hold_last = (hcnt == HW'(HL));

   assign busy       = run;
   assign blink_mask = (state == HOLD) ? 6'h3F : 6'h00;

   // Buffer contents are not reset; len alone marks the valid span.
   always_ff @(posedge clk) begin
      if (!reset && wr_accept) begin
         sym_buf[len[AW-1:0]] <= wr_code;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         len       <= '0;
         p         <= '0;
         tcnt      <= '0;
         hcnt      <= '0;
         held      <= 1'b0;
         pass_done <= 1'b0;
      end else begin
         pass_done <= 1'b0;
         if (run) begin
            tcnt <= tick ? '0 : tcnt + TW'(1);
         end
         if (stop) begin
            state <= IDLE;
            tcnt  <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (load) begin
                     len   <= '0;
                     state <= LOAD;
                  end
               end
               LOAD: begin
                  if (load) begin
                     len <= '0;
                  end else begin
                     if (wr_accept) begin
                        len <= len + LW'(1);
                     end
                     if (start && len != '0) begin
                        state <= SCROLL;
                        p     <= '0;
                        tcnt  <= '0;
                        held  <= 1'b0;
                     end
                  end
               end
               SCROLL: begin
                  if (tick) begin
                     if (last_sym && !held && HOLD_TICKS > 0) begin
                        state <= HOLD;
                        hcnt  <= '0;
                        held  <= 1'b1;
                     end else if (end_pass) begin
                        pass_done <= 1'b1;
                        if (loop) begin
                           p    <= '0;
                           held <= 1'b0;
                        end else begin
                           state <= IDLE;
                        end
                     end else begin
                        p <= p + PW'(1);
                     end
                  end
               end
               HOLD: begin
                  if (tick) begin
                     if (hold_last) begin
                        state <= SCROLL;
                        p     <= p + PW'(1);
                     end else begin
                        hcnt <= hcnt + HW'(1);
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // HEXk shows buf[p-k] when that index lies inside the message.
   always_comb begin
      logic [PW-1:0] d;
      logic [4:0]    cd;
      digit_codes = '0;
      for (int k = 0; k < 6; k++) begin
         d  = p - PW'(k);
         cd = BLANK_CODE;
         if (run && p >= PW'(k) && d < PW'(len)) begin
            cd = sym_buf[d[AW-1:0]];
         end
         digit_codes[5*k +: 5] = cd;
      end
   end

endmodule

// File: tb/tb_hex_marquee_ctrl.sv
// Scoreboard bench for hex_marquee_ctrl: stimulus queues expected
// snapshots per cycle, a negedge monitor pops and compares them.
module tb_hex_marquee_ctrl;

   localparam logic [4:0] B = 5'd31;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic        wr_valid = 1'b0;
   logic [4:0]  wr_code = 5'd0;
   logic        wr_ready;
   logic        start = 1'b0;
   logic        loop = 1'b0;
   logic        stop = 1'b0;
   logic [29:0] digit_codes;
   logic [5:0]  blink_mask;
   logic        busy;
   logic        pass_done;

   hex_marquee_ctrl #(
      .MAX_LEN   (4),
      .TICK_DIV  (2),
      .HOLD_TICKS(2),
      .BLANK_CODE(5'd31)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .wr_valid   (wr_valid),
      .wr_code    (wr_code),
      .wr_ready   (wr_ready),
      .start      (start),
      .loop       (loop),
      .stop       (stop),
      .digit_codes(digit_codes),
      .blink_mask (blink_mask),
      .busy       (busy),
      .pass_done  (pass_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      int unsigned cyc;
      logic [29:0] codes;
      logic [5:0]  mask;
      logic        busy;
      logic        wrr;
      logic        pd;
   } exp_t;

   exp_t        exp_q[$];
   string       name_q[$];
   int unsigned cyc = 0;
   int          nvec = 0;
   int          nerr = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [29:0] mk(
      input logic [4:0] h5, input logic [4:0] h4,
      input logic [4:0] h3, input logic [4:0] h2,
      input logic [4:0] h1, input logic [4:0] h0);
      return {h5, h4, h3, h2, h1, h0};
   endfunction

   task automatic chk_at(input int unsigned c, input string nm,
                         input logic [29:0] codes, input logic [5:0] m,
                         input logic b, input logic w, input logic pd);
      exp_t e;
      e.cyc   = c;
      e.codes = codes;
      e.mask  = m;
      e.busy  = b;
      e.wrr   = w;
      e.pd    = pd;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int unsigned c);
      while (cyc < c) step();
   endtask

   // Monitor: compare every snapshot due at or before this cycle.
   exp_t  me;
   string mn;
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         me = exp_q.pop_front();
         mn = name_q.pop_front();
         nvec++;
         if (me.cyc != cyc) begin
            nerr++;
            $display("FAIL %s: due cycle %0d, seen at cycle %0d",
                     mn, me.cyc, cyc);
         end else if (digit_codes !== me.codes || blink_mask !== me.mask ||
                      busy !== me.busy || wr_ready !== me.wrr ||
                      pass_done !== me.pd) begin
            nerr++;
            $display("FAIL %s @%0d: got codes=%h mask=%h busy=%b wrr=%b pd=%b, want codes=%h mask=%h busy=%b wrr=%b pd=%b",
                     mn, cyc, digit_codes, blink_mask, busy, wr_ready,
                     pass_done, me.codes, me.mask, me.busy, me.wrr, me.pd);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   logic [29:0] allb;
   int unsigned s, l;

   initial begin
      allb = mk(B, B, B, B, B, B);
      step();
      step();
      reset = 1'b0;
      chk_at(cyc, "reset", allb, 6'h00, 0, 0, 0);

      // 3-symbol pass, loop off
      load = 1'b1;
      step();
      load = 1'b0;
      chk_at(cyc, "load_idle", allb, 6'h00, 0, 1, 0);
      wr_valid = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         wr_code = 5'(i);
         step();
      end
      wr_valid = 1'b0;
      chk_at(cyc, "after_wr3", allb, 6'h00, 0, 1, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      s = cyc;
      chk_at(s, "p0", mk(B, B, B, B, B, 1), 6'h00, 1, 0, 0);
      chk_at(s + 2, "p1", mk(B, B, B, B, 1, 2), 6'h00, 1, 0, 0);
      chk_at(s + 4, "p2", mk(B, B, B, 1, 2, 3), 6'h00, 1, 0, 0);
      chk_at(s + 5, "p2_pre_hold", mk(B, B, B, 1, 2, 3), 6'h00, 1, 0, 0);
      chk_at(s + 6, "hold_first", mk(B, B, B, 1, 2, 3), 6'h3F, 1, 0, 0);
      chk_at(s + 9, "hold_last", mk(B, B, B, 1, 2, 3), 6'h3F, 1, 0, 0);
      chk_at(s + 10, "p3", mk(B, B, 1, 2, 3, B), 6'h00, 1, 0, 0);
      chk_at(s + 14, "p5", mk(1, 2, 3, B, B, B), 6'h00, 1, 0, 0);
      chk_at(s + 18, "p7", mk(3, B, B, B, B, B), 6'h00, 1, 0, 0);
      chk_at(s + 20, "p8", allb, 6'h00, 1, 0, 0);
      chk_at(s + 21, "p8_tick", allb, 6'h00, 1, 0, 0);
      chk_at(s + 22, "pass_done", allb, 6'h00, 0, 0, 1);
      chk_at(s + 23, "pd_one_cycle", allb, 6'h00, 0, 0, 0);
      wait_until(s + 24);

      // looping pass, then stop mid-HOLD
      load = 1'b1;
      step();
      load = 1'b0;
      wr_valid = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         wr_code = 5'(i);
         step();
      end
      wr_valid = 1'b0;
      loop = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      s = cyc;
      chk_at(s, "lp_p0", mk(B, B, B, B, B, 1), 6'h00, 1, 0, 0);
      chk_at(s + 20, "lp_p8", allb, 6'h00, 1, 0, 0);
      chk_at(s + 22, "lp_wrap", mk(B, B, B, B, B, 1), 6'h00, 1, 0, 1);
      chk_at(s + 23, "lp_pd_low", mk(B, B, B, B, B, 1), 6'h00, 1, 0, 0);
      chk_at(s + 28, "lp_hold2", mk(B, B, B, 1, 2, 3), 6'h3F, 1, 0, 0);
      wait_until(s + 29);
      stop = 1'b1;
      step();
      stop = 1'b0;
      loop = 1'b0;
      chk_at(cyc, "stop_idle", allb, 6'h00, 0, 0, 0);
      step();
      chk_at(cyc, "stop_no_pd", allb, 6'h00, 0, 0, 0);

      // empty start is ignored
      load = 1'b1;
      step();
      load = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk_at(cyc, "empty_start", allb, 6'h00, 0, 1, 0);
      chk_at(cyc + 2, "empty_stay", allb, 6'h00, 0, 1, 0);
      step();
      step();

      // overflow: 5 writes into 4 slots
      load = 1'b1;
      step();
      load = 1'b0;
      l = cyc;
      chk_at(l, "ovf_load", allb, 6'h00, 0, 1, 0);
      wr_valid = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         wr_code = 5'(i);
         step();
         if (i == 3) chk_at(cyc, "ovf_len3", allb, 6'h00, 0, 1, 0);
         if (i == 4) chk_at(cyc, "ovf_full", allb, 6'h00, 0, 0, 0);
         if (i == 5) chk_at(cyc, "ovf_drop", allb, 6'h00, 0, 0, 0);
      end
      wr_valid = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      s = cyc;
      chk_at(s, "ov_p0", mk(B, B, B, B, B, 1), 6'h00, 1, 0, 0);
      chk_at(s + 6, "ov_p3", mk(B, B, 1, 2, 3, 4), 6'h00, 1, 0, 0);
      chk_at(s + 8, "ov_hold", mk(B, B, 1, 2, 3, 4), 6'h3F, 1, 0, 0);
      chk_at(s + 11, "ov_hold_end", mk(B, B, 1, 2, 3, 4), 6'h3F, 1, 0, 0);
      chk_at(s + 12, "ov_p4", mk(B, 1, 2, 3, 4, B), 6'h00, 1, 0, 0);
      chk_at(s + 20, "ov_p8", mk(4, B, B, B, B, B), 6'h00, 1, 0, 0);
      chk_at(s + 22, "ov_p9", allb, 6'h00, 1, 0, 0);
      chk_at(s + 23, "ov_p9_tick", allb, 6'h00, 1, 0, 0);
      chk_at(s + 24, "ov_pass_done", allb, 6'h00, 0, 0, 1);
      chk_at(s + 25, "ov_idle", allb, 6'h00, 0, 0, 0);
      wait_until(s + 26);

      for (int i = 0; i < 50 && exp_q.size() > 0; i++) step();
      if (exp_q.size() > 0) begin
         $display("FAIL drain: %0d checks never reached", exp_q.size());
         $fatal(1, "drain");
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/hex_marquee_ctrl.md
Name: hex_marquee_ctrl

Overview:
- Scrolling-message sequencer for the six-digit HEX bank.
- Holds a short message of 5-bit alphaHex symbol codes and slides it right-to-left across HEX5..HEX0 at a prescaled tick rate.
- Raises per-digit blink requests, consumed by the per-digit blink drivers, while the message pauses.
- Sits between user/control logic and the six per-digit decode/blink instances.

Parameters:
- MAX_LEN, 16: message buffer depth in symbols (1..32).
- TICK_DIV, 25000000: clk cycles per scroll tick (>=1).
- HOLD_TICKS, 4: ticks to pause with all digits blinking once the last symbol reaches HEX0; 0 = no pause.
- BLANK_CODE, 5'd31: symbol code driven on unused digits.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock; all state updates on posedge clk.
- load  in  1  IDLE only: clear buffer length, enter LOAD.
- wr_valid  in  1  symbol write request.
- wr_code  in  5  symbol to append.
- wr_ready  out  1  high in LOAD while len < MAX_LEN.
- start  in  1  LOAD only: begin scrolling.
- loop  in  1  sampled at end of pass: 1 = repeat, 0 = stop.
- stop  in  1  abort to IDLE from any state.
- digit_codes  out  30  [5k+4:5k] = code for HEXk; k=0 is rightmost.
- blink_mask  out  6  bit k = HEXk should blink.
- busy  out  1  high in SCROLL or HOLD.
- pass_done  out  1  one-cycle pulse at end of each pass.

Behaviour:
- States: IDLE, LOAD, SCROLL, HOLD. Reset -> IDLE, len=0, p=0, tick counter=0, pass_done=0, held=0.
- IDLE: all digits BLANK_CODE, blink_mask=0, busy=0, wr_ready=0. load -> LOAD with len=0.
- LOAD:
  - A write is accepted when wr_valid & wr_ready: buf[len]<=wr_code, len<=len+1.
  - wr_valid while wr_ready=0 is dropped, no error.
  - load again clears len to 0.
  - start with len>=1 -> SCROLL with p=0, tick counter=0, held=0. start with len=0 is ignored.
  - Digits show blank during LOAD.
- Tick: the counter runs only in SCROLL/HOLD. It counts 0..TICK_DIV-1, and tick=1 on the cycle count==TICK_DIV-1, then wraps to 0.
- Display (combinational from registered p, len, buf): for HEXk, i = p - k.
  - 0 <= i < len: code = buf[i].
  - Otherwise: code = BLANK_CODE.
  - The first SCROLL cycle shows buf[0] on HEX0.
- SCROLL, on tick:
  - If p==len-1, held=0 and HOLD_TICKS>0: -> HOLD, hold counter=0, held<=1, p unchanged.
  - Else if p==len+5: end of pass. pass_done=1 on the next cycle. If loop: p<=0, held<=0, stay SCROLL. Otherwise -> IDLE.
  - Else p<=p+1.
- HOLD:
  - blink_mask=6'b111111; digits frozen.
  - Each tick increments the hold counter.
  - On the tick where the counter reaches HOLD_TICKS-1: -> SCROLL with p<=p+1.
- blink_mask=0 in all states other than HOLD.
- Priority: reset > stop > everything else. stop -> IDLE next cycle; buffer and len are retained; pass_done is not asserted. load/start/writes outside their state are ignored.
- p width must hold MAX_LEN+5 without wrap.
- Tick counter width must be ceil(log2(TICK_DIV)), minimum 1.

Test Plan (TICK_DIV=2, HOLD_TICKS=2, MAX_LEN=4):
- Reset held 2 cycles -> digit_codes = six copies of 5'd31; blink_mask=0; busy=0; wr_ready=0; pass_done=0.
- load, write 1,2,3, start -> next cycle HEX0=1, others 31, busy=1. Two cycles later HEX1=1, HEX0=2. Two more cycles: HEX2=1, HEX1=2, HEX0=3.
- Continue from previous -> at p=2 tick: enters HOLD, blink_mask=6'h3F for 4 cycles, digits unchanged. Then blink_mask=0 and HEX3=1, HEX2=2, HEX1=3, HEX0=31.
- load, write 1,2,3,4,5 with wr_valid held -> wr_ready falls after 4th accept; 5th dropped. Scroll shows only 1..4, and the last blank-out is at p=9.
- 3-symbol pass with loop=0 -> tick at p=8: pass_done high exactly 1 cycle, then IDLE, busy=0, all blank. Same with loop=1 -> HEX0=1 again, busy stays 1, HOLD recurs on second pass.
- stop asserted mid-HOLD -> next cycle IDLE, blink_mask=0, no pass_done. Then load + start with no writes -> stays LOAD, busy=0.
